bp_update_scheduler: RTL and testbench
======================================

// Module: bp_update_scheduler
// PURPOSE
//  Shares the single-port branch-predictor tables (local PHT, gshare PHT, chooser) between fetch-stage
//  lookups and EX-stage resolution updates. Buffers resolved branches in a small FIFO and drains one
//  update per granted cycle. Owns the global history register (GHR): speculative shift at fetch,
//  repair on mispredict. Sits between IF, the predictor tables/tournament chooser, and IDEX resolution.
// PARAMETERS
//  DEPTH  4  update FIFO entries (power of 2, >=2)
//  GHR_W  8  global history bits
//  IDX_W  8  table index bits (GHR_W <= IDX_W)
// PORTS
//  clk            in   1      sole clock, rising edge
//  rst            in   1      synchronous, active-high reset
//  lookup_req     in   1      IF requests a table read this cycle
//  lookup_pc      in   32     fetch PC (rv32i_word)
//  lookup_grant   out  1      table port given to the lookup this cycle
//  spec_valid     in   1      IF predicted a branch this cycle (shift GHR)
//  spec_taken     in   1      predicted direction for speculative shift
//  res_valid      in   1      EX resolved a branch/jump
//  res_ready      out  1      FIFO can accept (upstream holds res_* while low)
//  res_pc         in   32     PC of resolved branch
//  res_taken      in   1      actual outcome (branch&br_en | jump)
//  res_local_pred in   1      local component prediction carried down the pipe
//  res_global_pred in  1      global component prediction carried down the pipe
//  res_ghr        in   GHR_W  GHR snapshot taken at that branch's fetch
//  res_mispredict in   1      final tournament prediction was wrong
//  ghr            out  GHR_W  current (speculative) global history
//  tbl_en         out  1      table port active
//  tbl_we         out  1      1=update write, 0=lookup read
//  tbl_laddr      out  IDX_W  local/chooser index
//  tbl_gaddr      out  IDX_W  gshare index
//  tbl_taken      out  1      outcome to train PHTs
//  tbl_local_ok   out  1      local component was correct (chooser training)
//  tbl_global_ok  out  1      global component was correct (chooser training)
// BEHAVIOUR
//  - Reset: FIFO empty, ghr=0, res_ready=1 next cycle, all tbl_* and lookup_grant=0.
//  - Push: res_valid&res_ready on edge N -> entry at FIFO head visible cycle N+1 (earliest write N+1).
//  - res_ready = ~full (registered occupancy); push when full is never accepted, no same-cycle push/pop bypass.
//  - Arbitration per cycle: if FIFO full and not empty -> drain wins, lookup_grant=0 (IF stalls);
//    else lookup_req wins; else drain if non-empty; else tbl_en=0.
//  - Lookup: tbl_en=1, tbl_we=0, laddr=lookup_pc[IDX_W+1:2], gaddr=laddr ^ {0,ghr}. Combinational.
//  - Drain: tbl_en=tbl_we=1, laddr=res_pc[IDX_W+1:2], gaddr=laddr ^ {0,res_ghr} from entry;
//    tbl_local_ok=(local_pred==taken), tbl_global_ok=(global_pred==taken); head pops at edge.
//  - GHR: res_valid&res_ready&res_mispredict -> ghr<={res_ghr[GHR_W-2:0],res_taken}, overrides
//    spec_valid in the same cycle; else spec_valid -> ghr<={ghr[GHR_W-2:0],spec_taken}.
//  - Mispredict does not flush the FIFO (entries are architecturally resolved).
//  - Pointers are log2(DEPTH)+1 bits; wrap is natural; full = MSBs differ, low bits equal.
//  - rst mid-drain: pending updates discarded, port idle next cycle; no partial write.
// STRUCTURE
//  - rv32i_types: add bp_update_t {rv32i_word pc; logic taken, local_pred, global_pred; logic [GHR_W-1:0] ghr;}.
//  - One sub-module: bp_update_fifo (sync FIFO of bp_update_t, DEPTH entries, push/pop/full/empty).
//  - Arbiter, index hash and GHR logic stay in this module.
// TESTING
//  - rst high 2 cycles -> ghr=0, tbl_en=0, res_ready=1, lookup_grant=0.
//  - lookup_req=1, pc=0x100, ghr=0x05 -> grant=1, tbl_we=0, laddr=0x40, gaddr=0x45.
//  - push res_pc=0x104 taken=1 local_pred=0 global_pred=1, no lookup -> next cycle tbl_we=1,
//    laddr=0x41, tbl_taken=1, local_ok=0, global_ok=1; FIFO empty after.
//  - 4 pushes with lookup_req held high -> res_ready=0 after 4th; next cycle lookup_grant=0 and drain writes.
//  - spec_valid=1 taken=1 and mispredict res_ghr=0xA0 taken=0 same cycle -> ghr=0x40 next cycle.
//  - rst asserted with 3 entries queued -> next cycle empty, res_ready=1, no tbl_we pulse.

Source files
------------

// File: rtl/bp_update_scheduler_pkg.sv
// Shared types for the branch-predictor update scheduler: the queued update record
// and the table-port selector.
package bp_update_scheduler_pkg;

  localparam int BP_DEPTH = 4;
  localparam int BP_GHR_W = 8;
  localparam int BP_IDX_W = 8;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    rv32i_word             pc;
    logic                  taken;
    logic                  local_pred;
    logic                  global_pred;
    logic [BP_GHR_W-1:0]   ghr;
  } bp_update_t;

  typedef enum logic [1:0] {
    PORT_IDLE   = 2'd0,
    PORT_LOOKUP = 2'd1,
    PORT_DRAIN  = 2'd2
  } port_sel_e;

endpackage

// File: rtl/bp_update_fifo.sv
// Synchronous FIFO of resolved-branch updates; head entry is read combinationally.
module bp_update_fifo
  import bp_update_scheduler_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  bp_update_t din,
  input  logic       pop,
  output bp_update_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  bp_update_t  mem_q [DEPTH];
  bp_update_t  mem_d [DEPTH];
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Arbitrates the single-port predictor tables between fetch lookups and queued
// resolution updates, and owns the speculative global history register.
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int DEPTH = BP_DEPTH,
  parameter int GHR_W = BP_GHR_W,
  parameter int IDX_W = BP_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_req,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_grant,
  input  logic             spec_valid,
  input  logic             spec_taken,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic             res_local_pred,
  input  logic             res_global_pred,
  input  logic [GHR_W-1:0] res_ghr,
  input  logic             res_mispredict,
  output logic [GHR_W-1:0] ghr,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_laddr,
  output logic [IDX_W-1:0] tbl_gaddr,
  output logic             tbl_taken,
  output logic             tbl_local_ok,
  output logic             tbl_global_ok
);

  // Handshake: an update transfers on a rising edge where res_valid & res_ready;
  // upstream holds every res_* input stable while res_ready is low.

  logic [GHR_W-1:0] ghr_q, ghr_d;
  bp_update_t       push_entry, head;
  logic             fifo_full, fifo_empty, push, pop;
  port_sel_e        port_sel;

  bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    push_entry = '{pc: res_pc, taken: res_taken, local_pred: res_local_pred,
                   global_pred: res_global_pred, ghr: res_ghr};

    // A full queue stalls fetch so resolved updates cannot back up into EX.
    port_sel = PORT_IDLE;
    if (!rst) begin
      if (fifo_full)        port_sel = PORT_DRAIN;
      else if (lookup_req)  port_sel = PORT_LOOKUP;
      else if (!fifo_empty) port_sel = PORT_DRAIN;
    end

    res_ready     = ~rst & ~fifo_full;
    push          = res_valid & res_ready;
    pop           = (port_sel == PORT_DRAIN);
    lookup_grant  = (port_sel == PORT_LOOKUP);
    tbl_en        = (port_sel != PORT_IDLE);
    tbl_we        = pop;
    tbl_laddr     = '0;
    tbl_gaddr     = '0;
    tbl_taken     = 1'b0;
    tbl_local_ok  = 1'b0;
    tbl_global_ok = 1'b0;

    case (port_sel)
      PORT_LOOKUP: begin
        tbl_laddr = lookup_pc[IDX_W+1:2];
        tbl_gaddr = lookup_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
      end
      PORT_DRAIN: begin
        tbl_laddr     = head.pc[IDX_W+1:2];
        tbl_gaddr     = head.pc[IDX_W+1:2] ^ IDX_W'(head.ghr);
        tbl_taken     = head.taken;
        tbl_local_ok  = (head.local_pred == head.taken);
        tbl_global_ok = (head.global_pred == head.taken);
      end
      default: ;
    endcase

    // Repair from the mispredicted branch's snapshot beats this cycle's speculation.
    ghr_d = ghr_q;
    if (push && res_mispredict) ghr_d = {res_ghr[GHR_W-2:0], res_taken};
    else if (spec_valid)        ghr_d = {ghr_q[GHR_W-2:0], spec_taken};
  end

  assign ghr = ghr_q;

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Randomized and directed bench for bp_update_scheduler against a queue-based model.
module tb_bp_update_scheduler;
  import bp_update_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_req;
  logic [31:0] lookup_pc;
  logic        lookup_grant;
  logic        spec_valid, spec_taken;
  logic        res_valid, res_ready;
  logic [31:0] res_pc;
  logic        res_taken, res_local_pred, res_global_pred, res_mispredict;
  logic [7:0]  res_ghr;
  logic [7:0]  ghr;
  logic        tbl_en, tbl_we, tbl_taken, tbl_local_ok, tbl_global_ok;
  logic [7:0]  tbl_laddr, tbl_gaddr;

  always #5 clk = ~clk;

  bp_update_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_req      (lookup_req),
    .lookup_pc       (lookup_pc),
    .lookup_grant    (lookup_grant),
    .spec_valid      (spec_valid),
    .spec_taken      (spec_taken),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_pc          (res_pc),
    .res_taken       (res_taken),
    .res_local_pred  (res_local_pred),
    .res_global_pred (res_global_pred),
    .res_ghr         (res_ghr),
    .res_mispredict  (res_mispredict),
    .ghr             (ghr),
    .tbl_en          (tbl_en),
    .tbl_we          (tbl_we),
    .tbl_laddr       (tbl_laddr),
    .tbl_gaddr       (tbl_gaddr),
    .tbl_taken       (tbl_taken),
    .tbl_local_ok    (tbl_local_ok),
    .tbl_global_ok   (tbl_global_ok)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        lp;
    logic        gp;
    logic [7:0]  ghr;
  } ent_t;

  ent_t       exp_q[$];
  logic [7:0] m_ghr;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against what the model says this cycle must look like.
  task automatic model_check();
    int  occ;
    bit  e_ready, e_grant, e_drain;
    logic [7:0] la, ga;
    occ     = exp_q.size();
    e_ready = !rst && occ < 4;
    e_grant = !rst && lookup_req && occ < 4;
    e_drain = !rst && (occ == 4 || (!lookup_req && occ > 0));
    chk("ghr", ghr, m_ghr);
    chk("res_ready", res_ready, e_ready);
    chk("lookup_grant", lookup_grant, e_grant);
    chk("tbl_en", tbl_en, e_grant || e_drain);
    chk("tbl_we", tbl_we, e_drain);
    if (e_grant) begin
      la = 8'((lookup_pc >> 2) & 32'hFF);
      chk("lookup_laddr", tbl_laddr, la);
      chk("lookup_gaddr", tbl_gaddr, la ^ m_ghr);
    end
    if (e_drain) begin
      la = 8'((exp_q[0].pc >> 2) & 32'hFF);
      ga = la ^ exp_q[0].ghr;
      chk("drain_laddr", tbl_laddr, la);
      chk("drain_gaddr", tbl_gaddr, ga);
      chk("drain_taken", tbl_taken, exp_q[0].taken);
      chk("drain_local_ok", tbl_local_ok, exp_q[0].lp == exp_q[0].taken);
      chk("drain_global_ok", tbl_global_ok, exp_q[0].gp == exp_q[0].taken);
    end
  endtask

  task automatic model_commit();
    int   occ;
    bit   drain, acc;
    ent_t e;
    occ   = exp_q.size();
    acc   = !rst && res_valid && occ < 4;
    drain = !rst && (occ == 4 || (!lookup_req && occ > 0));
    last_acc = acc;
    if (rst) begin
      exp_q.delete();
      m_ghr = 8'h00;
    end else begin
      if (drain) void'(exp_q.pop_front());
      if (acc) begin
        e.pc = res_pc; e.taken = res_taken; e.lp = res_local_pred;
        e.gp = res_global_pred; e.ghr = res_ghr;
        exp_q.push_back(e);
      end
      if (acc && res_mispredict) m_ghr = {res_ghr[6:0], res_taken};
      else if (spec_valid)       m_ghr = {m_ghr[6:0], spec_taken};
    end
  endtask

  task automatic step();
    #1;
    model_check();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lookup_req = 0; lookup_pc = '0; spec_valid = 0; spec_taken = 0;
    res_valid = 0; res_pc = '0; res_taken = 0; res_local_pred = 0;
    res_global_pred = 0; res_ghr = '0; res_mispredict = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    m_ghr = 8'h00;
    @(posedge clk);
    #1;
    step();
    step();

    // Reset state
    rst = 1'b0;
    #1;
    chk("rst_ghr", ghr, 8'h00);
    chk("rst_tbl_en", tbl_en, 1'b0);
    chk("rst_res_ready", res_ready, 1'b1);
    chk("rst_grant", lookup_grant, 1'b0);
    step();

    // Build ghr = 0b101 and perform a lookup
    spec_valid = 1; spec_taken = 1; step();
    spec_taken = 0; step();
    spec_taken = 1; step();
    spec_valid = 0;
    lookup_req = 1; lookup_pc = 32'h100;
    #1;
    chk("lk_ghr", ghr, 8'h05);
    chk("lk_grant", lookup_grant, 1'b1);
    chk("lk_we", tbl_we, 1'b0);
    chk("lk_laddr", tbl_laddr, 8'h40);
    chk("lk_gaddr", tbl_gaddr, 8'h45);
    step();
    lookup_req = 0;

    // Single update drains the next cycle
    res_valid = 1; res_pc = 32'h104; res_taken = 1; res_local_pred = 0; res_global_pred = 1;
    step();
    clear_inputs();
    #1;
    chk("dr_we", tbl_we, 1'b1);
    chk("dr_laddr", tbl_laddr, 8'h41);
    chk("dr_taken", tbl_taken, 1'b1);
    chk("dr_local_ok", tbl_local_ok, 1'b0);
    chk("dr_global_ok", tbl_global_ok, 1'b1);
    step();
    #1;
    chk("dr_empty_after", tbl_en, 1'b0);

    // Fill with lookups held high, then full forces a drain
    lookup_req = 1; lookup_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      res_valid = 1; res_pc = 32'h300 + 32'(i * 4); res_taken = i[0];
      step();
    end
    res_valid = 0;
    #1;
    chk("full_ready", res_ready, 1'b0);
    chk("full_grant", lookup_grant, 1'b0);
    chk("full_we", tbl_we, 1'b1);
    step();
    lookup_req = 0;
    for (int i = 0; i < 4; i++) step();

    // Mispredict repair beats speculative shift
    spec_valid = 1; spec_taken = 1;
    res_valid = 1; res_mispredict = 1; res_ghr = 8'hA0; res_taken = 0; res_pc = 32'h400;
    step();
    clear_inputs();
    #1;
    chk("repair_ghr", ghr, 8'h40);
    step();

    // Reset with three entries queued
    lookup_req = 1;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1; res_pc = 32'h500 + 32'(i * 4);
      step();
    end
    clear_inputs();
    rst = 1;
    #1;
    chk("rstq_no_we", tbl_we, 1'b0);
    step();
    rst = 0;
    #1;
    chk("rstq_ready", res_ready, 1'b1);
    chk("rstq_idle", tbl_en, 1'b0);
    chk("rstq_ghr", ghr, 8'h00);
    step();

    // Random traffic; unaccepted updates are held stable
    last_acc = 1;
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      lookup_req = ($urandom_range(0, 1) == 1);
      lookup_pc  = $urandom;
      spec_valid = ($urandom_range(0, 2) == 0);
      spec_taken = $urandom_range(0, 1);
      if (!(res_valid && !last_acc)) begin
        res_valid       = ($urandom_range(0, 1) == 1);
        res_pc          = $urandom;
        res_taken       = $urandom_range(0, 1);
        res_local_pred  = $urandom_range(0, 1);
        res_global_pred = $urandom_range(0, 1);
        res_ghr         = 8'($urandom);
        res_mispredict  = ($urandom_range(0, 3) == 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
